// File: rtl/data_memory_unit.sv
// Word-addressed data memory with a self-clearing INIT phase and a fixed-latency
// single-outstanding request/response handshake.
module data_memory_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  isLd,
   input  logic                  isSt,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [DATA_W/8-1:0]   byte_en,
   output logic [DATA_W-1:0]     data_out,
   output logic                  resp_valid,
   output logic                  resp_err
);

   localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       NB        = DATA_W / 8;
   localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [3:0]        WAIT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            nxt_state;
   logic [IDX_W-1:0]  clr_idx;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              err;
   logic              accept;
   logic [IDX_W-1:0]  idx;
   logic              cap_ld;
   logic              cap_err;
   logic [DATA_W-1:0] cap_data;

   // Full-width compare so high address bits can never alias into the array.
   assign in_range = (address < DEPTH_A);
   assign idx      = address[IDX_W-1:0];
   assign err      = !in_range || (isLd && isSt);

   always_comb begin
      nxt_state = state;
      accept    = 1'b0;
      case (state)
         INIT: if (clr_idx == LAST_IDX) nxt_state = IDLE;
         IDLE: begin
            if (req_valid && (isLd || isSt)) begin
               accept    = 1'b1;
               nxt_state = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: if (cnt == 4'd0) nxt_state = RESP;
         RESP: nxt_state = IDLE;
         default: nxt_state = INIT;
      endcase
      if (rst) begin
         nxt_state = INIT;
         accept    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         clr_idx <= '0;
         cnt     <= '0;
      end else begin
         state <= nxt_state;
         if (state == INIT) clr_idx <= clr_idx + IDX_W'(1);
         if (accept) cnt <= WAIT_LOAD;
         else if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      end
   end

   // Array has no reset; contents survive rst until INIT clears them.
   always_ff @(posedge clk) begin
      if ((state == INIT) && !rst) begin
         mem[clr_idx] <= '0;
      end else if (accept && isSt && !err) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (byte_en[b]) mem[idx][8*b +: 8] <= data_in[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_ld   <= 1'b0;
         cap_err  <= 1'b0;
         cap_data <= '0;
      end else if (accept) begin
         cap_ld   <= isLd;
         cap_err  <= err;
         cap_data <= (isLd && !err) ? mem[idx] : '0;
      end
   end

   assign req_ready  = !rst && (state == IDLE);
   assign resp_valid = !rst && (state == RESP);
   assign resp_err   = resp_valid && cap_err;
   assign data_out   = (resp_valid && cap_ld) ? cap_data : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: one instance at LATENCY=1, one at LATENCY=4,
// sharing clock, reset and request inputs.
module tb_data_memory_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        isLd = 1'b0;
   logic        isSt = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;
   logic [3:0]  byte_en = '0;

   logic        rdy1, rv1, err1;
   logic [31:0] dout1;
   logic        rdy4, rv4, err4;
   logic [31:0] dout4;

   logic        use4 = 1'b0;
   logic        cur_rdy, cur_rv, cur_err;
   logic [31:0] cur_dout;

   int checks   = 0;
   int failures = 0;
   int rv1_cnt  = 0;
   int rv4_cnt  = 0;

   always #5 clk = ~clk;

   data_memory_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
      .isLd(isLd), .isSt(isSt), .address(address), .data_in(data_in),
      .byte_en(byte_en), .data_out(dout1), .resp_valid(rv1), .resp_err(err1)
   );

   data_memory_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy4),
      .isLd(isLd), .isSt(isSt), .address(address), .data_in(data_in),
      .byte_en(byte_en), .data_out(dout4), .resp_valid(rv4), .resp_err(err4)
   );

   assign cur_rdy  = use4 ? rdy4  : rdy1;
   assign cur_rv   = use4 ? rv4   : rv1;
   assign cur_err  = use4 ? err4  : err1;
   assign cur_dout = use4 ? dout4 : dout1;

   always @(negedge clk) begin
      if (rv1) rv1_cnt++;
      if (rv4) rv4_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Holds reset for two edges, checks the selected instance's outputs during reset,
   // then counts rising edges until req_ready appears.
   task automatic apply_reset(output int n);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'd0, cur_rdy}, 32'd0);
      check("rst_valid", {31'd0, cur_rv}, 32'd0);
      check("rst_err", {31'd0, cur_err}, 32'd0);
      check("rst_dout", cur_dout, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!cur_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_req(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] din, input logic [3:0] be,
                          output int lat, output logic [31:0] dout, output logic rerr,
                          output logic busy_rdy, output logic aft_rdy, output logic aft_rv);
      @(negedge clk);
      req_valid = 1'b1;
      isLd      = ld;
      isSt      = st;
      address   = addr;
      data_in   = din;
      byte_en   = be;
      @(negedge clk);
      // Garbage fields after acceptance must not disturb the captured request.
      req_valid = 1'b0;
      isLd      = 1'b1;
      isSt      = 1'b1;
      address   = 32'd3;
      data_in   = 32'hFFFF_FFFF;
      byte_en   = 4'hF;
      lat       = 1;
      busy_rdy  = cur_rdy;
      while (!cur_rv && lat < 20) begin
         @(negedge clk);
         lat++;
         busy_rdy = busy_rdy | cur_rdy;
      end
      dout = cur_dout;
      rerr = cur_err;
      @(negedge clk);
      aft_rdy = cur_rdy;
      aft_rv  = cur_rv;
      isLd    = 1'b0;
      isSt    = 1'b0;
   endtask

   int          n, lat, c_before;
   logic [31:0] dout;
   logic        rerr, busy, ardy, arv;

   initial begin
      // LATENCY=1 instance
      use4 = 1'b0;
      apply_reset(n);
      check("init_cycles", n, 32'd64);

      run_req(1, 0, 32'd3, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("ld_init_lat", lat, 32'd1);
      check("ld_init_data", dout, 32'd0);
      check("ld_init_err", {31'd0, rerr}, 32'd0);

      run_req(0, 1, 32'd5, 32'hDEAD_BEEF, 4'hF, lat, dout, rerr, busy, ardy, arv);
      check("st_lat", lat, 32'd1);
      check("st_dout", dout, 32'd0);
      check("st_err", {31'd0, rerr}, 32'd0);
      check("st_busy_ready", {31'd0, busy}, 32'd0);
      check("st_after_ready", {31'd0, ardy}, 32'd1);
      check("st_after_valid", {31'd0, arv}, 32'd0);

      run_req(1, 0, 32'd5, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("ld5_lat", lat, 32'd1);
      check("ld5_data", dout, 32'hDEAD_BEEF);

      run_req(0, 1, 32'd5, 32'h1122_3344, 4'h5, lat, dout, rerr, busy, ardy, arv);
      run_req(1, 0, 32'd5, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("partial_data", dout, 32'hDE22_BE44);

      run_req(0, 1, 32'd5, 32'hFFFF_FFFF, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("be0_err", {31'd0, rerr}, 32'd0);
      check("be0_lat", lat, 32'd1);
      run_req(1, 0, 32'd5, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("be0_data", dout, 32'hDE22_BE44);

      run_req(1, 0, 32'd64, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("oor_ld_err", {31'd0, rerr}, 32'd1);
      check("oor_ld_data", dout, 32'd0);

      run_req(0, 1, 32'h0000_0105, 32'h5555_5555, 4'hF, lat, dout, rerr, busy, ardy, arv);
      check("nowrap_err", {31'd0, rerr}, 32'd1);

      run_req(1, 1, 32'd70, 32'h7777_7777, 4'hF, lat, dout, rerr, busy, ardy, arv);
      check("both70_err", {31'd0, rerr}, 32'd1);
      check("both70_data", dout, 32'd0);

      run_req(1, 1, 32'd5, 32'h9999_9999, 4'hF, lat, dout, rerr, busy, ardy, arv);
      check("both5_err", {31'd0, rerr}, 32'd1);
      check("both5_data", dout, 32'd0);
      run_req(1, 0, 32'd5, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("err_nowrite", dout, 32'hDE22_BE44);

      run_req(0, 1, 32'd63, 32'hA5A5_0F0F, 4'hF, lat, dout, rerr, busy, ardy, arv);
      run_req(1, 0, 32'd63, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("ld63_data", dout, 32'hA5A5_0F0F);
      check("ld63_err", {31'd0, rerr}, 32'd0);

      // Request with neither isLd nor isSt must be ignored.
      @(negedge clk);
      c_before  = rv1_cnt;
      req_valid = 1'b1;
      address   = 32'd5;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("nop_no_resp", rv1_cnt - c_before, 32'd0);
      check("nop_ready", {31'd0, rdy1}, 32'd1);

      // LATENCY=4 instance
      use4 = 1'b1;
      apply_reset(n);
      check("init4_cycles", n, 32'd64);

      run_req(1, 0, 32'd9, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("l4_lat", lat, 32'd4);
      check("l4_busy_ready", {31'd0, busy}, 32'd0);
      check("l4_after_ready", {31'd0, ardy}, 32'd1);
      check("l4_after_valid", {31'd0, arv}, 32'd0);
      check("l4_data", dout, 32'd0);

      run_req(0, 1, 32'd7, 32'h1234_5678, 4'hF, lat, dout, rerr, busy, ardy, arv);
      check("l4_st_lat", lat, 32'd4);
      run_req(1, 0, 32'd7, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("l4_ld7_data", dout, 32'h1234_5678);

      // Reset two cycles after acceptance aborts the response and re-clears the array.
      @(negedge clk);
      c_before  = rv4_cnt;
      req_valid = 1'b1;
      isLd      = 1'b1;
      address   = 32'd7;
      @(negedge clk);
      req_valid = 1'b0;
      isLd      = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!rdy4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_init_cycles", n, 32'd64);
      check("abort_no_resp", rv4_cnt - c_before, 32'd0);
      run_req(1, 0, 32'd7, 32'd0, 4'h0, lat, dout, rerr, busy, ardy, arv);
      check("abort_ld7_data", dout, 32'd0);
      check("abort_ld7_err", {31'd0, rerr}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: address port width in bits.
REQ-003 Parameter DEPTH, default 64: number of words in the array; SHALL be at least 2.
REQ-004 Parameter LATENCY, default 1: cycles from request acceptance to response; legal range 1..8.
REQ-005 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1: reset; synchronous and active-high.
REQ-007 req_valid  input  1: request present.
REQ-008 req_ready  output  1: block can accept a request this cycle.
REQ-009 isLd  input  1: request is a load.
REQ-010 isSt  input  1: request is a store.
REQ-011 address  input  ADDR_W: word index, not a byte address.
REQ-012 data_in  input  DATA_W: store data.
REQ-013 byte_en  input  DATA_W/8: per-byte store enables; bit i covers data bits 8i+7..8i.
REQ-014 data_out  output  DATA_W: load data, valid only with resp_valid.
REQ-015 resp_valid  output  1: one-cycle completion pulse.
REQ-016 resp_err  output  1: completion had an error; qualified by resp_valid.

Function
REQ-017 The block SHALL implement an FSM with four states: INIT, IDLE, WAIT and RESP.
REQ-018 INIT SHALL write zero to one word per cycle at indices 0..DEPTH-1 in ascending order, then move to IDLE; INIT SHALL last exactly DEPTH cycles.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request is accepted on a rising edge where req_valid=1, req_ready=1 and (isLd|isSt)=1; req_valid with isLd=isSt=0 SHALL be ignored (no response).
REQ-021 On acceptance the block SHALL capture all request fields; inputs after acceptance SHALL have no effect until the next acceptance.
REQ-022 Memory access occurs at the acceptance edge: a store writes the enabled bytes only (disabled bytes unchanged); a load captures mem[address].
REQ-023 Error cases, in which the array SHALL NOT be written and the captured load data SHALL be 0: address >= DEPTH (full ADDR_W compare, no wrap), or isLd=isSt=1.
REQ-024 A store with byte_en=0 SHALL be a legal no-write completion with resp_err=0.
REQ-025 Transitions on acceptance: LATENCY=1 goes IDLE->RESP; LATENCY>1 goes IDLE->WAIT, stays in WAIT for LATENCY-1 cycles via a down-counter, then goes to RESP.
REQ-026 resp_valid SHALL be 1 for exactly one cycle (RESP), which is cycle acceptance+LATENCY; RESP->IDLE unconditionally, so the next acceptance is possible no earlier than cycle acceptance+LATENCY+1.
REQ-027 During RESP, data_out SHALL equal the captured load data for a load and 0 for a store; outside RESP, data_out SHALL be 0.
REQ-028 resp_err SHALL be 1 in RESP for the error cases in REQ-023 and 0 otherwise; outside RESP it SHALL be 0.
REQ-029 A load SHALL return the array contents after all previously completed stores, including a store that completed in the immediately preceding transaction.

Reset
REQ-030 rst=1 in any state SHALL, at that edge, force INIT with the clear index at 0, drop any pending response and clear the latency counter.
REQ-031 While rst=1 and on the following edge, outputs SHALL be req_ready=0, resp_valid=0, resp_err=0 and data_out=0.
REQ-032 Reset asserted mid-INIT SHALL restart the clear at index 0.
REQ-033 Reset asserted in WAIT or RESP SHALL produce no resp_valid for the aborted request; a store accepted before reset remains written until INIT clears it.

Verification
REQ-034 Reset then INIT (DEPTH=64): req_ready stays 0 for 64 cycles, then rises; a load of any index returns 0 with resp_err=0.
REQ-035 Store then load (LATENCY=1): store 0xDEADBEEF to index 5 with byte_en=0xF, then load index 5 -> resp_valid one cycle after each acceptance; load data_out=0xDEADBEEF.
REQ-036 Partial store: index 5 holds 0xDEADBEEF; store 0x11223344 with byte_en=0x5 -> a subsequent load returns 0xDE22BE44.
REQ-037 Errors: load index 64 (DEPTH=64) -> resp_err=1, data_out=0; store to index 70 with isLd=isSt=1 -> resp_err=1 and the array is unchanged.
REQ-038 Latency: with LATENCY=4, a load accepted at cycle 10 -> resp_valid only at cycle 14; req_ready=0 in cycles 11-14 and 1 at cycle 15.
REQ-039 Reset mid-operation: with LATENCY=4, assert rst at acceptance+2 -> no resp_valid occurs, INIT re-runs for DEPTH cycles, and the previously stored word reads back as 0.
